clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Programmable clock-enable generator and divide-ratio controller for the VGA/display clock domain. Produces a square divided clock and a one-cycle tick per toggle. Accepts run-time divide-ratio changes over a valid/ready handshake and applies them only on a full-period boundary, so downstream timing logic never sees a truncated or stretched half-period. Sits between the system clock and the pixel/timing logic; a CPU register or mode selector drives the config port.

Parameters:
CNT_W, 16, width of the divide counter and of cfg_div/cur_div.
DEFAULT_DIV, 1, divide value loaded at reset; must fit in CNT_W bits.

Ports:
clk  in  1  system clock; all logic on posedge.
resetn  in  1  asynchronous active-low reset.
run  in  1  1 = divider counting; 0 = divider held idle.
cfg_valid  in  1  new divide value offered.
cfg_div  in  CNT_W  requested divide value; output period = 2*(cfg_div+1) clk cycles.
cfg_ready  out  1  controller can accept cfg_div.
cfg_done  out  1  one-cycle pulse: the new value is now in effect.
cur_div  out  CNT_W  divide value currently in effect.
div_clk  out  1  divided square clock, registered.
tick  out  1  one-cycle pulse in the same cycle div_clk toggles (registered, aligned with the toggle).

Behaviour:
- Reset (async, resetn=0): counter=0, div_clk=0, tick=0, cur_div=DEFAULT_DIV, pending=0, state=IDLE, cfg_ready=1, cfg_done=0.
- Divider with run=1: if counter >= cur_div, then counter<=0, div_clk toggles, tick<=1 for that cycle. Otherwise counter<=counter+1 and tick<=0. Each half-period is cur_div+1 clks. cur_div=0 toggles every clk (period 2).
- Divider with run=0: counter<=0, div_clk<=0, tick<=0. When run returns to 1, the first toggle (0->1) occurs cur_div+1 cycles later.
- FSM, three states:
  - IDLE: cfg_ready=1. On cfg_valid & cfg_ready, latch cfg_div into pending and go to WAIT. cfg_ready is 0 from the next cycle.
  - WAIT: cfg_ready=0; cfg_valid is ignored. The apply boundary is the terminal-count cycle in which div_clk goes 1->0, i.e. the end of a full period. On that cycle, cur_div<=pending and counter<=0 (the normal wrap), then go to DONE. If run=0 in WAIT, apply on the next cycle without waiting for a boundary.
  - DONE: cfg_done=1 for exactly one cycle, cfg_ready=0. Next state is IDLE.
- Handshake: the transfer happens only when valid and ready are both high. The requester must hold cfg_div stable only during the accept cycle. Back-to-back requests: the earliest next accept is the cycle after DONE.
- A new value equal to cur_div still completes the full WAIT/DONE sequence and the period is unaffected.
- The counter is compared with >=, so a counter above a freshly reduced value cannot occur. The value changes only when the counter is 0.
- All outputs are registered; there is no combinational path from inputs to outputs except through the FSM state.
- resetn asserted mid-WAIT discards pending and restores DEFAULT_DIV immediately.

Test Plan:
- Reset, DEFAULT_DIV=1, run=1: div_clk toggles every 2 clks (period 4); tick pulses every 2 clks; cur_div=1; cfg_ready=1.
- With run=1, cur_div=1, request cfg_div=4 while div_clk=1 mid half-period: cfg_ready drops the next cycle. The current high half finishes with 2 clks. The next periods are 10 clks (5 high/5 low). cfg_done pulses once, 1 cycle after the 1->0 apply edge; cur_div reads 4.
- Request cfg_div=0 from cur_div=4, then hold cfg_valid=1 through WAIT: exactly one transfer occurs; after apply, div_clk toggles every clk; a second accept happens only in IDLE.
- run=0 with cur_div=3: div_clk=0, tick=0, counter held. Request cfg_div=7: cfg_done pulses within 3 cycles of the accept. Set run=1: the first 0->1 toggle comes 8 clks later.
- Assert resetn=0 asynchronously during WAIT (pending=9, cur_div=2): outputs go to reset values immediately (not at the next clock edge); after release, the period is 4 (DEFAULT_DIV=1) and 9 is never applied.
- Request a value equal to cur_div (2->2): the full handshake completes, cfg_done pulses, and div_clk period stays 6 clks with no glitch.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable generator: square divided clock plus toggle tick,
// with divide-ratio updates accepted over valid/ready and applied on full-period boundaries.
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic [CNT_W-1:0] cur_div,
    output logic             div_clk,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] pending;
    logic             term;
    logic             accept;
    logic             apply;

    // Terminal count for the current half-period; >= keeps a shrunk divide value safe.
    assign term   = run && (counter >= cur_div);
    assign accept = (state == ST_IDLE) && cfg_valid;

    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Swap only where div_clk falls (end of a full period), or at once when idle.
                if (!run || (term && div_clk)) begin
                    apply     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
            cfg_done  <= 1'b0;
            pending   <= '0;
            cur_div   <= DEF_DIV;
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt == ST_IDLE);
            cfg_done  <= (state_nxt == ST_DONE);
            if (accept) pending <= cfg_div;
            if (apply)  cur_div <= pending;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else if (!run) begin
            counter <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else if (term) begin
            counter <= '0;
            div_clk <= ~div_clk;
            tick    <= 1'b1;
        end else begin
            counter <= counter + 1'b1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a cycle-level behavioural model predicts every
// output cycle; a monitor pops predictions and compares them with the DUT.
module tb_clk_div_ctrl;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic             dclk;
        logic             tck;
        logic [CNT_W-1:0] cur;
        logic             rdy;
        logic             dn;
    } obs_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_done;
    logic [CNT_W-1:0] cur_div;
    logic             div_clk;
    logic             tick;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    obs_t exp_q[$];

    // Model state: half-period length is m_cur+1, m_age counts cycles spent in this half.
    int m_cur;
    int m_age;
    int m_pend;
    int m_mode;   // 0 accepting, 1 waiting for boundary, 2 just applied
    bit m_clk;
    bit m_tick;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cur_div   (cur_div),
        .div_clk   (div_clk),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_obs();
        obs_t o;
        o.dclk = m_clk;
        o.tck  = m_tick;
        o.cur  = CNT_W'(m_cur);
        o.rdy  = (m_mode == 0);
        o.dn   = (m_mode == 2);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.dclk = div_clk;
        o.tck  = tick;
        o.cur  = cur_div;
        o.rdy  = cfg_ready;
        o.dn   = cfg_done;
        return o;
    endfunction

    task automatic model_reset();
        m_cur  = 1;
        m_age  = 0;
        m_pend = 0;
        m_mode = 0;
        m_clk  = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic model_advance(input bit r, input bit v, input int d);
        bit was_high;
        bit falls;
        was_high = m_clk;
        falls    = 1'b0;
        if (!r) begin
            m_age  = 0;
            m_clk  = 1'b0;
            m_tick = 1'b0;
        end else if (m_age + 1 > m_cur) begin
            m_clk  = !m_clk;
            m_tick = 1'b1;
            m_age  = 0;
            falls  = was_high;
        end else begin
            m_age  = m_age + 1;
            m_tick = 1'b0;
        end
        case (m_mode)
            0: if (v) begin m_pend = d; m_mode = 1; end
            1: if (!r || falls) begin m_cur = m_pend; m_mode = 2; end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check(input string name, input obs_t act, input obs_t want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got div_clk=%b tick=%b cur=%0d ready=%b done=%b, want div_clk=%b tick=%b cur=%0d ready=%b done=%b",
                      name, act.dclk, act.tck, act.cur, act.rdy, act.dn,
                      want.dclk, want.tck, want.cur, want.rdy, want.dn);
    endtask

    // Called at a negedge: drive inputs, predict the next edge, wait one cycle.
    task automatic step(input bit r, input bit v, input int d);
        run       = r;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        model_advance(r, v, d);
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n, input bit r);
        for (int i = 0; i < n; i++) step(r, 1'b0, 0);
    endtask

    task automatic async_reset();
        obs_t want;
        #2 resetn = 1'b0;
        #1;
        want = '{dclk: 1'b0, tck: 1'b0, cur: CNT_W'(1), rdy: 1'b1, dn: 1'b0};
        check("async_reset", dut_obs(), want);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    always @(posedge clk) begin
        obs_t want;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check($sformatf("cycle%0d", cyc), dut_obs(), want);
        end
    end

    initial begin
        obs_t want;
        int   guard;
        resetn    = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_reset();
        @(negedge clk);
        want = '{dclk: 1'b0, tck: 1'b0, cur: CNT_W'(1), rdy: 1'b1, dn: 1'b0};
        check("reset_state", dut_obs(), want);
        @(negedge clk);
        resetn = 1'b1;

        // Default divide: period 4.
        idle_steps(12, 1'b1);

        // Request 4 right after div_clk rose (mid high half).
        guard = 0;
        while (!(m_clk && m_age == 0) && guard < 10) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        step(1'b1, 1'b1, 4);
        idle_steps(30, 1'b1);

        // Request 0 holding valid high through the whole handshake and beyond.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 0);
        idle_steps(8, 1'b1);

        // Set 3, stop, request 7 while stopped, restart.
        step(1'b1, 1'b1, 3);
        idle_steps(15, 1'b1);
        idle_steps(4, 1'b0);
        step(1'b0, 1'b1, 7);
        idle_steps(4, 1'b0);
        idle_steps(40, 1'b1);

        // Set 2, then reset asynchronously while 9 is pending.
        step(1'b1, 1'b1, 2);
        idle_steps(15, 1'b1);
        step(1'b1, 1'b1, 9);
        async_reset();
        idle_steps(16, 1'b1);

        // Same-value request 2 -> 2.
        step(1'b1, 1'b1, 2);
        idle_steps(15, 1'b1);
        step(1'b1, 1'b1, 2);
        idle_steps(24, 1'b1);

        // Randomised traffic with occasional stops and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            else step($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 6)));
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d predictions left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
